// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Fills the instruction memory from a UART byte stream. A load frame is a
// 16-bit big-endian word count LEN, then LEN words, each sent MSB first.
// Words are written to consecutive addresses starting at 0 through port A of
// the instruction memory. The CPU is held (cpu_hold high) for the whole load.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        single-cycle pulse, begins a load when idle
//   rx_data      received byte
//   rx_valid     rx_data strobe, one cycle per byte, back-to-back allowed
//   mem_we       instruction memory write enable (wea), single-cycle pulses
//   mem_addr     instruction memory write address (addra)
//   mem_din      instruction memory write data (dina)
//   cpu_hold     high while loading; gates PC_write at the top level
//   load_done    sticky success flag, cleared by the next accepted start
//   load_error   sticky illegal-length flag, cleared by the next accepted start
//   words_loaded words written in the current or last load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  // Largest legal word count: the full memory capacity.
  localparam logic [16:0] MaxLen = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StDone,
    StError
  } state_e;

  state_e                 state_q;
  logic [15:0]            len_q;
  logic [1:0]             byte_idx_q;
  // Holds the first three bytes of the word in flight; separate from mem_din
  // so the next word can start shifting while a write is still presented.
  logic [DATA_WIDTH-9:0]  shift_q;

  logic [15:0]            len_full;
  logic                   len_ok;
  logic [ADDR_WIDTH:0]    words_inc;
  logic                   last_word;

  always_comb begin
    // Length as it will be once the low byte currently on rx_data is taken.
    len_full  = {len_q[15:8], rx_data};
    len_ok    = (len_full != 16'd0) && ({1'b0, len_full} <= MaxLen);
    words_inc = words_loaded + (ADDR_WIDTH + 1)'(1);
    last_word = (17'(words_inc) == {1'b0, len_q});
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      len_q        <= '0;
      byte_idx_q   <= '0;
      shift_q      <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_din      <= '0;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      // Write enable is a one-cycle pulse unless re-armed below.
      mem_we <= 1'b0;

      case (state_q)
        StIdle: begin
          // A byte arriving with start is dropped: rx_valid is not looked at here.
          if (start) begin
            state_q      <= StLenHi;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            mem_addr     <= '0;
          end
        end

        StLenHi: begin
          if (rx_valid) begin
            len_q[15:8] <= rx_data;
            state_q     <= StLenLo;
          end
        end

        StLenLo: begin
          if (rx_valid) begin
            len_q[7:0] <= rx_data;
            if (len_ok) begin
              byte_idx_q <= '0;
              state_q    <= StData;
            end else begin
              state_q <= StError;
            end
          end
        end

        StData: begin
          if (rx_valid) begin
            shift_q    <= {shift_q[DATA_WIDTH-17:0], rx_data};
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              mem_din <= {shift_q, rx_data};
              mem_we  <= 1'b1;
            end
          end
          // End of the write cycle: advance. The address wrap after the very
          // last word of a full-capacity load is harmless since we leave DATA.
          if (mem_we) begin
            mem_addr     <= mem_addr + ADDR_WIDTH'(1);
            words_loaded <= words_inc;
            if (last_word) begin
              state_q <= StDone;
            end
          end
        end

        StDone: begin
          cpu_hold  <= 1'b0;
          load_done <= 1'b1;
          state_q   <= StIdle;
        end

        StError: begin
          cpu_hold   <= 1'b0;
          load_error <= 1'b1;
          state_q    <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int unsigned AW = 10;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   words_loaded;

  imem_loader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (32)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  // Memory model plus write statistics.
  logic [31:0] tbmem [1024];
  int          wr_count = 0;
  int          we_run = 0;
  int          we_run_max = 0;
  int          hold_bad = 0;

  always @(posedge clock) begin
    if (mem_we) begin
      tbmem[mem_addr] = mem_din;
      wr_count = wr_count + 1;
      we_run = we_run + 1;
      if (we_run > we_run_max) we_run_max = we_run;
    end else begin
      we_run = 0;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    if (cpu_hold !== 1'b1) hold_bad = hold_bad + 1;
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Sends LEN then nw words taken from w0/w1; gap_mode 1 inserts 0..7 idle cycles.
  task automatic send_frame(input logic [15:0] len, input int nw, input logic [31:0] w0,
                            input logic [31:0] w1, input int gap_mode);
    logic [7:0] bytes [10];
    logic [31:0] w;
    int nb;
    bytes[0] = len[15:8];
    bytes[1] = len[7:0];
    nb = 2;
    for (int j = 0; j < nw; j++) begin
      w = (j == 0) ? w0 : w1;
      bytes[nb]   = w[31:24];
      bytes[nb+1] = w[23:16];
      bytes[nb+2] = w[15:8];
      bytes[nb+3] = w[7:0];
      nb = nb + 4;
    end
    for (int k = 0; k < nb; k++) begin
      send_byte(bytes[k], (gap_mode != 0) ? ((k * 3) % 8) : 0);
    end
  endtask

  task automatic wait_end(input string name);
    int k;
    k = 0;
    while (!(load_done || load_error) && k < 60) begin
      tick();
      k = k + 1;
    end
    if (!(load_done || load_error)) begin
      n_cmp = n_cmp + 1;
      n_fail = n_fail + 1;
      $display("FAIL %s timeout: no done/error after %0d cycles, expected one", name, k);
    end
  endtask

  typedef struct {
    logic [15:0] len;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    int          gap_mode;
    logic        exp_done;
    logic        exp_err;
    int          exp_words;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{16'h0002, 2, 32'hDEADBEEF, 32'h12345678, 0, 1'b1, 1'b0, 2};
    vecs[1] = '{16'h0002, 2, 32'hDEADBEEF, 32'h12345678, 1, 1'b1, 1'b0, 2};
    vecs[2] = '{16'h0000, 0, 32'h0,        32'h0,        0, 1'b0, 1'b1, 0};
    vecs[3] = '{16'h0401, 0, 32'h0,        32'h0,        0, 1'b0, 1'b1, 0};
    vecs[4] = '{16'h0001, 1, 32'hCAFEF00D, 32'h0,        1, 1'b1, 1'b0, 1};

    // Reset state.
    #7;
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset cpu_hold", 32'(cpu_hold), 32'd0);
    check("reset load_done", 32'(load_done), 32'd0);
    check("reset load_error", 32'(load_error), 32'd0);
    check("reset words_loaded", 32'(words_loaded), 32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    check("reset mem_din", mem_din, 32'd0);
    #1 reset_n = 1'b1;
    tick();

    // Table-driven frames.
    for (int i = 0; i < 5; i++) begin
      tbmem[0] = 32'h0;
      tbmem[1] = 32'h0;
      wr_count = 0;
      hold_bad = 0;
      pulse_start();
      check($sformatf("v%0d hold after start", i), 32'(cpu_hold), 32'd1);
      send_frame(vecs[i].len, vecs[i].nw, vecs[i].w0, vecs[i].w1, vecs[i].gap_mode);
      if (i == 0) begin
        // Latency after the final 4th-byte strobe.
        check("lat we after 4th byte", 32'(mem_we), 32'd1);
        check("lat din last word", mem_din, 32'h12345678);
        check("lat addr last word", 32'(mem_addr), 32'd1);
        tick();
        check("lat we drops", 32'(mem_we), 32'd0);
        check("lat hold still high", 32'(cpu_hold), 32'd1);
        check("lat done not yet", 32'(load_done), 32'd0);
        tick();
        check("lat done", 32'(load_done), 32'd1);
        check("lat hold released", 32'(cpu_hold), 32'd0);
      end
      wait_end($sformatf("v%0d", i));
      check($sformatf("v%0d load_done", i), 32'(load_done), 32'(vecs[i].exp_done));
      check($sformatf("v%0d load_error", i), 32'(load_error), 32'(vecs[i].exp_err));
      check($sformatf("v%0d words_loaded", i), 32'(words_loaded), 32'(vecs[i].exp_words));
      check($sformatf("v%0d write count", i), 32'(wr_count), 32'(vecs[i].exp_words));
      check($sformatf("v%0d hold during load", i), 32'(hold_bad), 32'd0);
      tick();
      check($sformatf("v%0d hold after end", i), 32'(cpu_hold), 32'd0);
      if (vecs[i].nw > 0) check($sformatf("v%0d mem[0]", i), tbmem[0], vecs[i].w0);
      if (vecs[i].nw > 1) check($sformatf("v%0d mem[1]", i), tbmem[1], vecs[i].w1);
    end

    // Full capacity: word k holds k.
    wr_count = 0;
    we_run_max = 0;
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 1024; k++) begin
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'(k >> 8), 0);
      send_byte(8'(k), 0);
    end
    wait_end("full");
    check("full load_done", 32'(load_done), 32'd1);
    check("full load_error", 32'(load_error), 32'd0);
    check("full words_loaded", 32'(words_loaded), 32'd1024);
    check("full write count", 32'(wr_count), 32'd1024);
    check("full mem[0]", tbmem[0], 32'h0);
    check("full mem[500]", tbmem[500], 32'h000001F4);
    check("full mem[1023]", tbmem[1023], 32'h000003FF);
    check("full addr wrapped", 32'(mem_addr), 32'd0);
    check("full we max run", 32'(we_run_max), 32'd1);

    // Idle bytes are ignored.
    tick();
    wr_count = 0;
    send_byte(8'h00, 1);
    send_byte(8'h01, 1);
    send_byte(8'h77, 1);
    check("idle no writes", 32'(wr_count), 32'd0);
    check("idle done kept", 32'(load_done), 32'd1);
    check("idle hold low", 32'(cpu_hold), 32'd0);

    // Start with a coincident byte: byte dropped. Start during DATA ignored.
    tbmem[0] = 32'h0;
    tbmem[1] = 32'h0;
    rx_data  = 8'hFF;
    rx_valid = 1'b1;
    pulse_start();
    rx_valid = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hA1, 0);
    send_byte(8'hB2, 0);
    pulse_start();
    send_byte(8'hC3, 0);
    send_byte(8'hD4, 1);
    pulse_start();
    send_byte(8'hE5, 0);
    send_byte(8'hF6, 0);
    send_byte(8'h07, 0);
    send_byte(8'h18, 0);
    wait_end("ign");
    check("ign load_done", 32'(load_done), 32'd1);
    check("ign words_loaded", 32'(words_loaded), 32'd2);
    check("ign mem[0]", tbmem[0], 32'hA1B2C3D4);
    check("ign mem[1]", tbmem[1], 32'hE5F60718);

    // New start after DONE clears load_done on that edge.
    tick();
    pulse_start();
    check("restart done cleared", 32'(load_done), 32'd0);
    check("restart hold", 32'(cpu_hold), 32'd1);
    check("restart words cleared", 32'(words_loaded), 32'd0);
    send_frame(16'h0000, 0, 32'h0, 32'h0, 0);
    wait_end("restart");
    check("restart error", 32'(load_error), 32'd1);
    check("restart done stays low", 32'(load_done), 32'd0);

    // Asynchronous reset mid-word.
    tick();
    pulse_start();
    send_frame(16'h0001, 0, 32'h0, 32'h0, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #3 reset_n = 1'b0;
    #1;
    check("areset cpu_hold", 32'(cpu_hold), 32'd0);
    check("areset mem_we", 32'(mem_we), 32'd0);
    check("areset load_error", 32'(load_error), 32'd0);
    check("areset load_done", 32'(load_done), 32'd0);
    check("areset words", 32'(words_loaded), 32'd0);
    check("areset mem_din", mem_din, 32'd0);
    #2 reset_n = 1'b1;
    tick();
    tbmem[0] = 32'h0;
    wr_count = 0;
    pulse_start();
    send_frame(16'h0001, 1, 32'h11223344, 32'h0, 0);
    wait_end("post reset");
    check("post reset done", 32'(load_done), 32'd1);
    check("post reset words", 32'(words_loaded), 32'd1);
    check("post reset mem[0]", tbmem[0], 32'h11223344);
    check("post reset writes", 32'(wr_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
